nmea_src_arb: RTL and testbench

Sentence-level arbiter that shares the single character input of the NMEA sentence parser between several byte sources (one per GPS receiver/UART). Grants the parser to one source from a `$` through its terminating CR, round-robin among sources presenting `$`. Respects the parser's full flag and recovers from stalled senders by timeout. Sits between the UART receive FIFOs and the parser's `i_write`/`i_char`/`o_full` port.

---
 rtl/nmea_pkg.sv | 17 +
 rtl/nmea_src_arb_if.sv | 31 +++
 rtl/rr_pick.sv | 35 +++
 rtl/nmea_src_arb.sv | 172 +++++++++++++++++
 tb/tb_nmea_src_arb.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nmea_pkg.sv
// Shared definitions for the NMEA sentence path.
//   CH_DOLLAR / CH_STAR / CH_CR : ASCII characters the arbiter reacts to or injects
//   arb_state_t                 : source arbiter state encoding
package nmea_pkg;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FWD      = 2'd1,
    INJ_STAR = 2'd2,
    INJ_CR   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/nmea_src_arb_if.sv
// Character bus between the per-source UART receive FIFOs, the source
// arbiter and the NMEA sentence parser.
//   i_valid [N_SRC]   per-source character valid
//   i_char  [8*N_SRC] per-source character, source s on bits [8s+7:8s]
//   o_ready [N_SRC]   per-source accept (transfer when valid && ready)
//   o_write           write strobe to the parser
//   o_char  [8]       character to the parser
//   i_full            parser FIFO full
// Modports: slave = arbiter view, master = sources/parser (bench) view.
interface nmea_src_arb_if #(
  parameter int unsigned N_SRC = 2
) ();

  logic [N_SRC-1:0]   i_valid;
  logic [8*N_SRC-1:0] i_char;
  logic [N_SRC-1:0]   o_ready;
  logic               o_write;
  logic [7:0]         o_char;
  logic               i_full;

  modport slave (
    input  i_valid, i_char, i_full,
    output o_ready, o_write, o_char
  );

  modport master (
    output i_valid, i_char, i_full,
    input  o_ready, o_write, o_char
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational one-hot round-robin picker.
//   i_req  [N_REQ] request vector
//   i_last [IW]    index of the previous winner; search starts at i_last+1
//   o_grant[N_REQ] one-hot winner, 0 when no request
//   o_any          at least one request present
module rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IW    = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_any
);

  logic found;

  // Offset k walks the cyclic order last+1, last+2, ..., last+N_REQ;
  // the inner loop keeps every request index constant.
  always_comb begin
    o_grant = '0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      for (int unsigned s = 0; s < N_REQ; s++) begin
        if (!found && i_req[s] && (s == ((32'(i_last) + k) % N_REQ))) begin
          o_grant[s] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/nmea_src_arb.sv
// Sentence-level arbiter sharing the NMEA parser character input between
// N_SRC byte sources. A source presenting '$' in IDLE is granted (round
// robin) and owns the parser until its CR is written; an owner idle for
// TIMEOUT cycles loses the sentence.
//   i_clk, i_rst       clock, asynchronous active-low reset
//   bus (slave)        source valid/char/ready and parser write/char/full
//   o_grant [N_SRC]    one-hot current owner, 0 when idle
//   o_busy             sentence in progress
//   o_drop             one-cycle pulse when a sentence is aborted by timeout
// Build option: NMEA_ARB_ABORT_EN defined -> an aborted sentence is closed
// by writing '*' then CR to the parser, o_drop pulses with the CR write.
module nmea_src_arb
  import nmea_pkg::*;
#(
  parameter int unsigned N_SRC   = 2,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic             i_clk,
  input  logic             i_rst,
  nmea_src_arb_if.slave    bus,
  output logic [N_SRC-1:0] o_grant,
  output logic             o_busy,
  output logic             o_drop
);

  localparam int unsigned IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  arb_state_t       state_r, state_nx;
  logic [IW-1:0]    owner_r, last_r, win_idx;
  logic [CW-1:0]    cnt_r;
  logic [N_SRC-1:0] cand, win_oh;
  logic             win_any;
  logic             own_valid;
  logic [7:0]       own_char;
  logic             own_xfer, cr_xfer, timeout_hit;

  always_comb begin
    for (int unsigned s = 0; s < N_SRC; s++) begin
      cand[s] = bus.i_valid[s] && (bus.i_char[8*s +: 8] == CH_DOLLAR);
    end
  end

  rr_pick #(
    .N_REQ (N_SRC),
    .IW    (IW)
  ) u_pick (
    .i_req   (cand),
    .i_last  (last_r),
    .o_grant (win_oh),
    .o_any   (win_any)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned s = 0; s < N_SRC; s++) begin
      if (win_oh[s]) win_idx = IW'(s);
    end
  end

  always_comb begin
    own_valid = 1'b0;
    own_char  = '0;
    for (int unsigned s = 0; s < N_SRC; s++) begin
      if (owner_r == IW'(s)) begin
        own_valid = bus.i_valid[s];
        own_char  = bus.i_char[8*s +: 8];
      end
    end
  end

  assign own_xfer = (state_r == FWD) && own_valid && !bus.i_full;
  assign cr_xfer  = own_xfer && (own_char == CH_CR);
  // Fires on the idle cycle that would take the counter to TIMEOUT. A CR
  // transfer implies own_valid, so it can never coincide with this.
  assign timeout_hit = (state_r == FWD) && !own_valid && !bus.i_full &&
                       (cnt_r == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_r <= IDLE;
    else        state_r <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: if (win_any) state_nx = FWD;
      FWD: begin
        if (cr_xfer) begin
          state_nx = IDLE;
        end else if (timeout_hit) begin
`ifdef NMEA_ARB_ABORT_EN
          state_nx = INJ_STAR;
`else
          state_nx = IDLE;
`endif
        end
      end
`ifdef NMEA_ARB_ABORT_EN
      INJ_STAR: if (!bus.i_full) state_nx = INJ_CR;
      INJ_CR:   if (!bus.i_full) state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Owner, round-robin pointer and owner-idle counter
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      owner_r <= '0;
      last_r  <= IW'(N_SRC - 1);
      cnt_r   <= '0;
    end else begin
      if (state_r == IDLE) begin
        cnt_r <= '0;
        if (win_any) owner_r <= win_idx;
      end
      if (state_r == FWD) begin
        if (own_xfer)                        cnt_r <= '0;
        else if (!own_valid && !bus.i_full) cnt_r <= cnt_r + 1'b1;
      end
      if (cr_xfer || timeout_hit) last_r <= owner_r;
    end
  end

  // Output logic; everything is forced low while reset is asserted so a
  // mid-sentence reset silences the outputs in the same cycle.
  always_comb begin
    bus.o_ready = '0;
    bus.o_write = 1'b0;
    bus.o_char  = '0;
    o_grant     = '0;
    o_busy      = 1'b0;
    o_drop      = 1'b0;
    if (i_rst) begin
      o_busy = (state_r != IDLE);
      for (int unsigned s = 0; s < N_SRC; s++) begin
        o_grant[s] = (state_r != IDLE) && (owner_r == IW'(s));
      end
      case (state_r)
        // Non-'$' characters ahead of a sentence are accepted and dropped;
        // candidates (winner included) are held until FWD.
        IDLE: bus.o_ready = bus.i_valid & ~cand;
        FWD: begin
          for (int unsigned s = 0; s < N_SRC; s++) begin
            bus.o_ready[s] = (owner_r == IW'(s)) && !bus.i_full;
          end
          bus.o_write = own_xfer;
          bus.o_char  = own_char;
`ifndef NMEA_ARB_ABORT_EN
          o_drop = timeout_hit;
`endif
        end
`ifdef NMEA_ARB_ABORT_EN
        INJ_STAR: begin
          bus.o_write = !bus.i_full;
          bus.o_char  = CH_STAR;
        end
        INJ_CR: begin
          bus.o_write = !bus.i_full;
          bus.o_char  = CH_CR;
          o_drop      = !bus.i_full;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nmea_src_arb.sv
// Directed self-checking bench for nmea_src_arb (N_SRC=2, TIMEOUT=16).
// Expectations for the abort path follow NMEA_ARB_ABORT_EN when defined.
module tb_nmea_src_arb;
  import nmea_pkg::*;

  localparam int unsigned N_SRC   = 2;
  localparam int unsigned TIMEOUT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]       ch [N_SRC];
  logic [N_SRC-1:0] vld;
  logic             full;

  nmea_src_arb_if #(.N_SRC(N_SRC)) bus ();

  assign bus.i_char  = {ch[1], ch[0]};
  assign bus.i_valid = vld;
  assign bus.i_full  = full;

  logic [N_SRC-1:0] o_grant;
  logic             o_busy;
  logic             o_drop;

  nmea_src_arb #(
    .N_SRC   (N_SRC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst_n),
    .bus     (bus),
    .o_grant (o_grant),
    .o_busy  (o_busy),
    .o_drop  (o_drop)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge, where inputs change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present '$' from src while IDLE: held (not accepted), nothing written.
  task automatic req_idle(input logic src, input string tag);
    vld[src] = 1'b1;
    ch[src]  = CH_DOLLAR;
    #1;
    check({tag, "_idle_rdy"}, 32'(bus.o_ready[src]), 32'd0);
    check({tag, "_idle_wr"},  32'(bus.o_write), 32'd0);
    check({tag, "_idle_gnt"}, 32'(o_grant), 32'd0);
    tick();
  endtask

  // Owner src in FWD, parser not full: one character written per cycle.
  task automatic stream(input logic src, input string s, input string tag);
    logic [31:0] one_hot;
    one_hot = src ? 32'd2 : 32'd1;
    for (int i = 0; i < s.len(); i++) begin
      vld[src] = 1'b1;
      ch[src]  = s[i];
      #1;
      check({tag, "_wr"},  32'(bus.o_write), 32'd1);
      check({tag, "_ch"},  32'(bus.o_char), 32'(s[i]));
      check({tag, "_gnt"}, 32'(o_grant), one_hot);
      check({tag, "_rdy"}, 32'(bus.o_ready), one_hot);
      tick();
    end
    vld[src] = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"},  32'(bus.o_ready), 32'd0);
    check({tag, "_wr"},   32'(bus.o_write), 32'd0);
    check({tag, "_ch"},   32'(bus.o_char), 32'd0);
    check({tag, "_gnt"},  32'(o_grant), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_drop"}, 32'(o_drop), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_w, seen_d;
    vld   = '0;
    ch[0] = 8'h00;
    ch[1] = 8'h00;
    full  = 1'b0;

    // Reset state, with a garbage character offered during reset
    repeat (3) @(posedge clk);
    #1;
    vld[0] = 1'b1;
    ch[0]  = "x";
    #1;
    check_all_zero("rst");
    vld   = '0;
    rst_n = 1'b1;
    tick();

    // T1: single sentence from source 0
    req_idle(1'b0, "t1");
    stream(1'b0, "$GPHDT,123.4,T*2C\015", "t1");
    #1;
    check("t1_end_busy", 32'(o_busy), 32'd0);
    check("t1_end_gnt",  32'(o_grant), 32'd0);
    tick();

    // T2: both sources present '$' right after reset; source 0 first
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    vld[0] = 1'b1; ch[0] = CH_DOLLAR;
    vld[1] = 1'b1; ch[1] = CH_DOLLAR;
    #1;
    check("t2_tie_rdy", 32'(bus.o_ready), 32'd0);
    check("t2_tie_wr",  32'(bus.o_write), 32'd0);
    tick();
    stream(1'b0, "$A\015", "t2a");
    #1;
    check("t2_gap_gnt", 32'(o_grant), 32'd0);
    check("t2_gap_rdy", 32'(bus.o_ready), 32'd0);
    check("t2_gap_wr",  32'(bus.o_write), 32'd0);
    tick();
    stream(1'b1, "$B\015", "t2b");
    #1;
    check("t2_end_busy", 32'(o_busy), 32'd0);
    tick();

    // T3: leading garbage on source 1 accepted and discarded
    vld[1] = 1'b1; ch[1] = "x";
    #1;
    check("t3_x_rdy", 32'(bus.o_ready), 32'd2);
    check("t3_x_wr",  32'(bus.o_write), 32'd0);
    tick();
    ch[1] = "y";
    #1;
    check("t3_y_rdy", 32'(bus.o_ready), 32'd2);
    check("t3_y_wr",  32'(bus.o_write), 32'd0);
    tick();
    req_idle(1'b1, "t3");
    stream(1'b1, "$Z\015", "t3");
    #1;
    check("t3_end_busy", 32'(o_busy), 32'd0);
    tick();

    // T4: 15 counted idle cycles split around a 50-cycle full stall
    req_idle(1'b0, "t4");
    stream(1'b0, "$A", "t4a");
    seen_w = 1'b0;
    seen_d = 1'b0;
    repeat (10) begin
      #1;
      seen_w |= bus.o_write;
      seen_d |= o_drop;
      tick();
    end
    full = 1'b1;
    ch[0] = "B";
    for (int c = 0; c < 50; c++) begin
      vld[0] = (c % 2 == 0);
      #1;
      seen_w |= bus.o_write;
      seen_d |= o_drop;
      tick();
    end
    full   = 1'b0;
    vld[0] = 1'b0;
    repeat (5) begin
      #1;
      seen_w |= bus.o_write;
      seen_d |= o_drop;
      tick();
    end
    check("t4_no_write", 32'(seen_w), 32'd0);
    check("t4_no_drop",  32'(seen_d), 32'd0);
    check("t4_busy",     32'(o_busy), 32'd1);
    stream(1'b0, "B,C\015", "t4b");
    #1;
    check("t4_end_busy", 32'(o_busy), 32'd0);
    tick();

    // T5: owner stalls after "$GPH"
    req_idle(1'b0, "t5");
    stream(1'b0, "$GPH", "t5");
    seen_w = 1'b0;
    seen_d = 1'b0;
    repeat (15) begin
      #1;
      seen_w |= bus.o_write;
      seen_d |= o_drop;
      tick();
    end
    check("t5_pre_wr",   32'(seen_w), 32'd0);
    check("t5_pre_drop", 32'(seen_d), 32'd0);
    #1;
    check("t5_to_wr",   32'(bus.o_write), 32'd0);
    check("t5_to_busy", 32'(o_busy), 32'd1);
`ifdef NMEA_ARB_ABORT_EN
    check("t5_to_drop", 32'(o_drop), 32'd0);
    tick();
    full = 1'b1;
    #1;
    check("t5_star_full_wr", 32'(bus.o_write), 32'd0);
    check("t5_star_full_dr", 32'(o_drop), 32'd0);
    tick();
    full = 1'b0;
    #1;
    check("t5_star_wr",  32'(bus.o_write), 32'd1);
    check("t5_star_ch",  32'(bus.o_char), 32'(CH_STAR));
    check("t5_star_dr",  32'(o_drop), 32'd0);
    check("t5_star_rdy", 32'(bus.o_ready), 32'd0);
    check("t5_star_gnt", 32'(o_grant), 32'd1);
    tick();
    #1;
    check("t5_cr_wr", 32'(bus.o_write), 32'd1);
    check("t5_cr_ch", 32'(bus.o_char), 32'(CH_CR));
    check("t5_cr_dr", 32'(o_drop), 32'd1);
    tick();
`else
    check("t5_to_drop", 32'(o_drop), 32'd1);
    tick();
`endif
    #1;
    check("t5_end_busy", 32'(o_busy), 32'd0);
    check("t5_end_gnt",  32'(o_grant), 32'd0);
    check("t5_end_wr",   32'(bus.o_write), 32'd0);
    check("t5_end_drop", 32'(o_drop), 32'd0);
    tick();

    // T6: reset in the middle of a sentence
    req_idle(1'b0, "t6");
    stream(1'b0, "$GP", "t6a");
    vld[0] = 1'b1;
    ch[0]  = "H";
    #1;
    check("t6_pre_wr", 32'(bus.o_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    tick();
    vld[0] = 1'b0;
    rst_n  = 1'b1;
    tick();
    req_idle(1'b0, "t6b");
    stream(1'b0, "$X\015", "t6b");
    #1;
    check("t6_end_busy", 32'(o_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
